// File: rtl/des_dec_if.sv
// Handshake and datapath bundle between the DES decrypt round sequencer and
// its environment: request/operands in, round-function loop, result out.
interface des_dec_if;
  logic        start;
  logic [31:0] L_in;
  logic [31:0] R_in;
  logic [27:0] C0;
  logic [27:0] D0;
  logic [31:0] L_o;
  logic [31:0] R_o;
  logic [31:0] L_i;
  logic [31:0] R_i;
  logic [55:0] Key_cd;
  logic [3:0]  round_num;
  logic        busy;
  logic        done;
  logic [63:0] data_o;

  modport master (
    output start, L_in, R_in, C0, D0, L_o, R_o,
    input  L_i, R_i, Key_cd, round_num, busy, done, data_o
  );

  modport slave (
    input  start, L_in, R_in, C0, D0, L_o, R_o,
    output L_i, R_i, Key_cd, round_num, busy, done, data_o
  );
endinterface

// File: rtl/des_dec_ctrl.sv
// DES decryption round sequencer: loads IP(ciphertext) and PC-1(key), steps the
// external round function 16 times with a right-rotating key, returns {R16,L16}.
module des_dec_ctrl (
  input  logic      clk,
  input  logic      reset,
  des_dec_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUND,
    S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] l_q, l_nxt;
  logic [31:0] r_q, r_nxt;
  logic [27:0] c_q, c_nxt;
  logic [27:0] d_q, d_nxt;
  logic [3:0]  round_q, round_nxt;
  logic        busy_q, busy_nxt;
  logic        done_q, done_nxt;
  logic [63:0] data_q, data_nxt;
  logic        rot_two;

  // Rotation into decrypt round n+2 undoes the encrypt left shift of round 15-n:
  // single-bit steps happen only when leaving rounds 1, 8 and 15.
  assign rot_two = !((round_q == 4'd0) || (round_q == 4'd7) || (round_q == 4'd14));

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  // NOTE: every variable gets its hold/default value before the case so no
  // path through this block leaves one unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    l_nxt     = l_q;
    r_nxt     = r_q;
    c_nxt     = c_q;
    d_nxt     = d_q;
    round_nxt = round_q;
    busy_nxt  = busy_q;
    done_nxt  = 1'b0;
    data_nxt  = data_q;

    case (state)
      S_IDLE: begin
        if (bus.start) begin
          l_nxt     = bus.L_in;
          r_nxt     = bus.R_in;
          c_nxt     = bus.C0;
          d_nxt     = bus.D0;
          round_nxt = 4'd0;
          busy_nxt  = 1'b1;
          state_nxt = S_ROUND;
        end
      end
      S_ROUND: begin
        if (round_q == 4'd15) begin
          // Round 16 result is swapped on capture; round inputs stay frozen.
          data_nxt  = {bus.R_o, bus.L_o};
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = S_DONE;
        end else begin
          l_nxt     = bus.L_o;
          r_nxt     = bus.R_o;
          c_nxt     = rotr28(c_q, rot_two);
          d_nxt     = rotr28(d_q, rot_two);
          round_nxt = round_q + 4'd1;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      l_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state   <= state_nxt;
      l_q     <= l_nxt;
      r_q     <= r_nxt;
      c_q     <= c_nxt;
      d_q     <= d_nxt;
      round_q <= round_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
      data_q  <= data_nxt;
    end
  end

  assign bus.L_i       = l_q;
  assign bus.R_i       = r_q;
  assign bus.Key_cd    = {c_q, d_q};
  assign bus.round_num = round_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.data_o    = data_q;

endmodule

// File: tb/tb_des_dec_ctrl.sv
// Directed bench for des_dec_ctrl with a behavioural DES round function closing
// the loop; expected values are hand constants or an independent encrypt model.
module tb_des_dec_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  des_dec_if bus ();

  des_dec_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  localparam int E_TAB[48] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11,
                               12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
                               22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
  localparam int P_TAB[32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                               2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
  localparam int PC2_TAB[48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
                                 23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
                                 41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                                 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int ENC_SHIFT[16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam logic [255:0] SBOX[8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  localparam logic [31:0] FIPS_L   = 32'h0A4CD995;
  localparam logic [31:0] FIPS_R   = 32'h43423234;
  localparam logic [27:0] FIPS_C   = 28'hF0CCAAF;
  localparam logic [27:0] FIPS_D   = 28'h556678F;
  localparam logic [63:0] FIPS_OUT = 64'hCC00CCFF_F0AAF0AA;

  function automatic logic [31:0] des_f(input logic [31:0] r, input logic [55:0] cd);
    logic [47:0]  e, k, x;
    logic [31:0]  s, p;
    logic [5:0]   six;
    logic [255:0] sb;
    int           idx;
    for (int i = 0; i < 48; i++) begin
      e[47-i] = r[32-E_TAB[i]];
      k[47-i] = cd[56-PC2_TAB[i]];
    end
    x = e ^ k;
    for (int j = 0; j < 8; j++) begin
      six = x[47-6*j -: 6];
      idx = (int'(six[5]) * 32) + (int'(six[0]) * 16) + int'(six[4:1]);
      sb  = SBOX[j];
      s[31-4*j -: 4] = sb[255-4*idx -: 4];
    end
    for (int i = 0; i < 32; i++) p[31-i] = s[32-P_TAB[i]];
    return p;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input int n);
    int m;
    m = n % 28;
    if (m == 0) return x;
    return (x << m) | (x >> (28 - m));
  endfunction

  // Decrypt round k uses the encrypt key of round 17-k.
  function automatic logic [55:0] dec_key(input logic [27:0] c, input logic [27:0] d, input int k);
    int cum;
    cum = 0;
    for (int i = 0; i < 17 - k; i++) cum += ENC_SHIFT[i];
    return {rotl28(c, cum), rotl28(d, cum)};
  endfunction

  // Returns the encrypt pre-output {R16,L16}.
  function automatic logic [63:0] des_enc(input logic [31:0] l, input logic [31:0] r,
                                          input logic [27:0] c, input logic [27:0] d);
    logic [31:0] t;
    for (int i = 0; i < 16; i++) begin
      c = rotl28(c, ENC_SHIFT[i]);
      d = rotl28(d, ENC_SHIFT[i]);
      t = r;
      r = l ^ des_f(r, {c, d});
      l = t;
    end
    return {r, l};
  endfunction

  always_comb begin
    bus.L_o = bus.R_i;
    bus.R_o = bus.L_i ^ des_f(bus.R_i, bus.Key_cd);
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [31:0] l, input logic [31:0] r,
                       input logic [27:0] c, input logic [27:0] d);
    bus.start = s;
    bus.L_in  = l;
    bus.R_in  = r;
    bus.C0    = c;
    bus.D0    = d;
  endtask

  // Called #1 after an edge in IDLE; lat = edges after the accepting edge until done.
  task automatic run_op(input logic [31:0] l, input logic [31:0] r, input logic [27:0] c,
                        input logic [27:0] d, output logic [63:0] res, output int lat);
    drive(1'b1, l, r, c, d);
    tick();
    bus.start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      tick();
      if (bus.done) lat = i;
    end
    res = bus.data_o;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] res, enc, pt;
    logic [27:0] rc, rd;
    int          lat, dones, first_d, bad;
    int          dt[$];

    reset = 1'b1;
    drive(1'b0, '0, '0, '0, '0);
    tick();
    tick();
    check("rst_round_num", bus.round_num, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_L_i", bus.L_i, 0);
    check("rst_R_i", bus.R_i, 0);
    check("rst_Key_cd", bus.Key_cd, 0);
    check("rst_data_o", bus.data_o, 0);

    // FIPS vector with full key-schedule and latency trace; start on first edge after reset.
    reset = 1'b0;
    drive(1'b1, FIPS_L, FIPS_R, FIPS_C, FIPS_D);
    tick();
    bus.start = 1'b0;
    check("e0_busy", bus.busy, 1);
    check("e0_round_num", bus.round_num, 0);
    check("e0_L_i", bus.L_i, FIPS_L);
    check("e0_R_i", bus.R_i, FIPS_R);
    check("key_round1", bus.Key_cd, {FIPS_C, FIPS_D});
    for (int k = 1; k <= 15; k++) begin
      tick();
      check($sformatf("round_num_e%0d", k), bus.round_num, k);
      check($sformatf("key_round%0d", k + 1), bus.Key_cd, dec_key(FIPS_C, FIPS_D, k + 1));
      check($sformatf("busy_e%0d", k), bus.busy, 1);
      check($sformatf("done_e%0d", k), bus.done, 0);
      if (k == 1) check("key_round2_const", bus.Key_cd, {28'hF866557, 28'hAAB33C7});
    end
    tick();
    check("e16_done", bus.done, 1);
    check("e16_busy", bus.busy, 0);
    check("e16_round_num", bus.round_num, 15);
    check("e16_key_round16", bus.Key_cd, {rotl28(FIPS_C, 1), rotl28(FIPS_D, 1)});
    check("fips_data_o", bus.data_o, FIPS_OUT);
    tick();
    check("e17_done", bus.done, 0);
    check("e17_data_hold", bus.data_o, FIPS_OUT);

    // Start pulses with other data at round 3, round 15 and in DONE are ignored.
    drive(1'b1, FIPS_L, FIPS_R, FIPS_C, FIPS_D);
    tick();
    drive(1'b0, 32'h11111111, 32'h22222222, 28'h3333333, 28'h4444444);
    dones = 0;
    for (int i = 1; i <= 50; i++) begin
      bus.start = (i == 4) || (i == 16) || (i == 17);
      tick();
      if (bus.done) dones++;
    end
    bus.start = 1'b0;
    check("busy_start_done_count", dones, 1);
    check("busy_start_data_o", bus.data_o, FIPS_OUT);
    check("busy_start_idle_busy", bus.busy, 0);

    // Asynchronous reset in round 8 clears everything at once and suppresses done.
    drive(1'b1, 32'h01234567, 32'h89ABCDEF, 28'h0F0F0F0, 28'h1234567);
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("pre_abort_round_num", bus.round_num, 8);
    #2 reset = 1'b1;
    #1;
    check("abort_round_num", bus.round_num, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_L_i", bus.L_i, 0);
    check("abort_R_i", bus.R_i, 0);
    check("abort_Key_cd", bus.Key_cd, 0);
    check("abort_data_o", bus.data_o, 0);
    tick();
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done || bus.busy) dones++;
    end
    check("abort_no_done", dones, 0);
    run_op(FIPS_L, FIPS_R, FIPS_C, FIPS_D, res, lat);
    check("post_abort_latency", lat, 16);
    check("post_abort_data_o", res, FIPS_OUT);

    // start held high: accepted every 18 cycles, data_o steady between pulses.
    tick();
    drive(1'b1, FIPS_L, FIPS_R, FIPS_C, FIPS_D);
    first_d = 0;
    bad = 0;
    for (int i = 1; i <= 56; i++) begin
      tick();
      if (bus.done) begin
        dt.push_back(i);
        first_d = 1;
      end
      if (first_d != 0 && bus.data_o !== FIPS_OUT) bad++;
    end
    bus.start = 1'b0;
    check("b2b_done_count", dt.size(), 3);
    if (dt.size() == 3) begin
      check("b2b_first_done", dt[0], 17);
      check("b2b_spacing_1", dt[1] - dt[0], 18);
      check("b2b_spacing_2", dt[2] - dt[1], 18);
    end
    check("b2b_data_stable", bad, 0);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    // Round trip against the independent encrypt model.
    for (int n = 0; n < 100; n++) begin
      pt  = {$urandom, $urandom};
      rc  = 28'($urandom);
      rd  = 28'($urandom);
      enc = des_enc(pt[63:32], pt[31:0], rc, rd);
      run_op(enc[63:32], enc[31:0], rc, rd, res, lat);
      check($sformatf("roundtrip_%0d", n), res, pt);
      if (lat != 16) check($sformatf("roundtrip_latency_%0d", n), lat, 16);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
